chunked_add_sub: RTL and testbench

//  Multi-cycle adder/subtractor lane in the Execute ALU, directly downstream of the operand complement stage.

---
 rtl/chunked_add_sub.sv | 162 ++++++++++++++++
 tb/tb_chunked_add_sub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sub.sv
// ============================================================================
//  Module   : chunked_add_sub
//  Brief    : Multi-cycle adder/subtractor, CHUNK bits per cycle, LSB slice
//             first, with N/Z/C/V flags over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_add_sub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b_comp,
   input  logic             subs,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic               flag_n_q, flag_n_d;
   logic               flag_z_q, flag_z_d;
   logic               flag_c_q, flag_c_d;
   logic               flag_v_q, flag_v_d;

   logic [CHUNK:0]     slice_res;
   logic [WIDTH-1:0]   sum_next;
   logic               last_slice;

   // Operands shift right each cycle so the active slice is always at bit 0;
   // result slices enter at the top and settle into place after NCHUNK steps.
   assign slice_res  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};
   assign sum_next   = (sum_q >> CHUNK)
                     | (WIDTH'(slice_res[CHUNK-1:0]) << (WIDTH - CHUNK));
   assign last_slice = (count_q == CNT_W'(NCHUNK - 1));

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      carry_d  = carry_q;
      count_d  = count_q;
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
      flag_v_d = flag_v_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b_comp;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b_comp[WIDTH-1];
               carry_d = subs;
               count_d = '0;
               sum_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            sum_d   = sum_next;
            carry_d = slice_res[CHUNK];
            count_d = count_q + CNT_W'(1);
            if (last_slice) begin
               count_d  = '0;
               flag_n_d = sum_next[WIDTH-1];
               flag_z_d = (sum_next == '0);
               flag_c_d = slice_res[CHUNK];
               flag_v_d = (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         carry_q     <= 1'b0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         flag_n_q    <= 1'b0;
         flag_z_q    <= 1'b0;
         flag_c_q    <= 1'b0;
         flag_v_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
         carry_q     <= carry_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         flag_n_q    <= flag_n_d;
         flag_z_q    <= flag_z_d;
         flag_c_q    <= flag_c_d;
         flag_v_q    <= flag_v_d;
      end
   end

   // Reset gates in_ready immediately so nothing is accepted while it is high.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign flag_n    = flag_n_q;
   assign flag_z    = flag_z_q;
   assign flag_c    = flag_c_q;
   assign flag_v    = flag_v_q;

endmodule

`default_nettype wire

// File: tb/tb_chunked_add_sub.sv
// ============================================================================
//  Module   : tb_chunked_add_sub
//  Brief    : Directed self-checking bench for chunked_add_sub (8-bit, 2-bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunked_add_sub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = 8'h00;
   logic [7:0] b_comp = 8'h00;
   logic       subs = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] sum;
   logic       flag_n, flag_z, flag_c, flag_v;

   int n_tests = 0;
   int n_fail  = 0;

   chunked_add_sub #(.WIDTH(8), .CHUNK(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b_comp    (b_comp),
      .subs      (subs),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_tests++;
      if ({out_valid, in_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_handshake: out_valid,in_ready=%b required 00", {out_valid, in_ready});
      end
      n_tests++;
      if ({sum, flag_n, flag_z, flag_c, flag_v} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: sum=%h nzcv=%b%b%b%b required 00 0000",
                  sum, flag_n, flag_z, flag_c, flag_v);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   // Runs one operation; inputs are scrambled right after acceptance.
   task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                         input logic ts, input logic [7:0] exp_sum, input logic [3:0] exp_nzcv);
      int cyc;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready_before: in_ready=%b required 1", name, in_ready);
      end
      a = ta; b_comp = tb; subs = ts; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = ~ta; b_comp = ~tb; subs = ~ts;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_busy_ready: in_ready=%b required 0", name, in_ready);
      end
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         step();
         cyc++;
      end
      n_tests++;
      if (cyc !== 4) begin
         n_fail++;
         $display("FAIL %s_latency: cycles=%0d required 4", name, cyc);
      end
      n_tests++;
      if (sum !== exp_sum) begin
         n_fail++;
         $display("FAIL %s_sum: sum=%h required %h", name, sum, exp_sum);
      end
      n_tests++;
      if ({flag_n, flag_z, flag_c, flag_v} !== exp_nzcv) begin
         n_fail++;
         $display("FAIL %s_flags: nzcv=%b required %b", name,
                  {flag_n, flag_z, flag_c, flag_v}, exp_nzcv);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL %s_retire: out_valid,in_ready=%b required 01", name, {out_valid, in_ready});
      end
   endtask

   task automatic test_add();
      run_op("add_5_3",     8'h05, 8'h03, 1'b0, 8'h08, 4'b0000);
      run_op("sub_5_5",     8'h05, 8'hFA, 1'b1, 8'h00, 4'b0110);
      run_op("ovf_7f_1",    8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001);
      run_op("ripple_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110);
      run_op("neg_ovf_80",  8'h80, 8'h80, 1'b0, 8'h00, 4'b0111);
      run_op("borrow_3_5",  8'h03, 8'hFA, 1'b1, 8'hFE, 4'b1000);
   endtask

   task automatic test_stall();
      int cyc;
      a = 8'h12; b_comp = 8'h34; subs = 1'b0; in_valid = 1'b1;
      step();
      a = 8'hAA; b_comp = 8'h55;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         step();
         cyc++;
      end
      n_tests++;
      if (cyc !== 4) begin
         n_fail++;
         $display("FAIL stall_latency: cycles=%0d required 4", cyc);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({out_valid, in_ready, sum, flag_n, flag_z, flag_c, flag_v} !== {2'b10, 8'h46, 4'b0000}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: ov=%b ir=%b sum=%h nzcv=%b%b%b%b required ov=1 ir=0 sum=46 nzcv=0000",
                     i, out_valid, in_ready, sum, flag_n, flag_z, flag_c, flag_v);
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_tests++;
      if ({out_valid, in_ready, sum} !== {2'b01, 8'h46}) begin
         n_fail++;
         $display("FAIL stall_release: ov=%b ir=%b sum=%h required ov=0 ir=1 sum=46",
                  out_valid, in_ready, sum);
      end
      // out_ready in IDLE must be harmless.
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL idle_out_ready: out_valid,in_ready=%b required 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_reset_abort();
      logic seen;
      a = 8'h0F; b_comp = 8'h01; subs = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_during_rst: out_valid,in_ready=%b required 00", {out_valid, in_ready});
      end
      step();
      rst = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL abort_after_rst: out_valid,in_ready=%b required 01", {out_valid, in_ready});
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_result: out_valid_seen=%b required 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      run_op("b2b_1", 8'h3C, 8'h0F, 1'b0, 8'h4B, 4'b0000);
      run_op("b2b_2", 8'hC0, 8'hBF, 1'b1, 8'h80, 4'b1010);
   endtask

   initial begin
      test_reset();
      test_add();
      test_stall();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
